// File: rtl/mem_access_unit.sv
// Load/store access unit: one outstanding data-memory access with RV size/sign handling.
// Optional build macro MEM_ACCESS_MISALIGN_TRAP_EN: misaligned accesses complete with rsp_err
// instead of being rounded down to size alignment.
module mem_access_unit #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [2:0]          req_funct3,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                stall,
    output logic                rsp_valid,
    output logic [XLEN-1:0]     rsp_rdata,
    output logic                rsp_err,
    output logic [ADDR_W-1:0]   dmem_address,
    output logic                dmem_read,
    output logic                dmem_write,
    output logic [XLEN-1:0]     dmem_wdata,
    output logic [XLEN/8-1:0]   dmem_byte_enable,
    input  logic [XLEN-1:0]     dmem_rdata,
    input  logic                dmem_resp
);

    localparam int unsigned BE_W  = XLEN / 8;
    localparam int unsigned OFF_W = $clog2(BE_W);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    logic [OFF_W-1:0]  off_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic              write_q;

    logic [1:0]        req_size_c;
    logic [3:0]        req_nbytes_c;
    logic [OFF_W-1:0]  req_off_c;
    logic [8:0]        be_mask_c;
    logic [BE_W-1:0]   req_be_c;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    logic              req_misal_c;
`endif

    // Request decode; a double on a 32-bit datapath degrades to full width.
    always_comb begin
        req_size_c = req_funct3[1:0];
        if (XLEN == 32 && req_size_c == 2'd3) begin
            req_size_c = 2'd2;
        end
        req_nbytes_c = 4'd1 << req_size_c;
        req_off_c    = req_addr[OFF_W-1:0] & ~OFF_W'(req_nbytes_c - 4'd1);
        be_mask_c    = (9'd1 << req_nbytes_c) - 9'd1;
        req_be_c     = BE_W'(be_mask_c) << req_off_c;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        req_misal_c  = (req_addr[OFF_W-1:0] & OFF_W'(req_nbytes_c - 4'd1)) != '0;
`endif
    end

    logic [XLEN-1:0] shifted_c;
    logic [XLEN-1:0] load_c;
    logic            sign_c;
    int              nbits;

    // Align the returned word to bit 0 and extend above the access size.
    always_comb begin
        shifted_c = dmem_rdata >> {off_q, 3'b000};
        nbits     = 8 << size_q;
        case (size_q)
            2'd0:    sign_c = shifted_c[7];
            2'd1:    sign_c = shifted_c[15];
            2'd2:    sign_c = shifted_c[31];
            default: sign_c = shifted_c[XLEN-1];
        endcase
        load_c = shifted_c;
        for (int i = 0; i < XLEN; i++) begin
            if (i >= nbits) begin
                load_c[i] = ~uns_q & sign_c;
            end
        end
    end

    assign req_ready = (state == IDLE);
    assign stall     = (req_valid && state == IDLE) || (state == BUSY);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            off_q            <= '0;
            size_q           <= '0;
            uns_q            <= 1'b0;
            write_q          <= 1'b0;
            rsp_valid        <= 1'b0;
            rsp_rdata        <= '0;
            dmem_address     <= '0;
            dmem_read        <= 1'b0;
            dmem_write       <= 1'b0;
            dmem_wdata       <= '0;
            dmem_byte_enable <= '0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
            rsp_err          <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        off_q            <= req_off_c;
                        size_q           <= req_size_c;
                        uns_q            <= req_funct3[2];
                        write_q          <= req_write;
                        state            <= BUSY;
                        dmem_address     <= {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
                        dmem_read        <= ~req_write;
                        dmem_write       <= req_write;
                        dmem_wdata       <= req_wdata << {req_off_c, 3'b000};
                        dmem_byte_enable <= req_write ? req_be_c : '0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
                        rsp_err          <= 1'b0;
                        // Trapped access skips memory entirely.
                        if (req_misal_c) begin
                            state            <= DONE;
                            dmem_read        <= 1'b0;
                            dmem_write       <= 1'b0;
                            dmem_byte_enable <= '0;
                            rsp_valid        <= 1'b1;
                            rsp_err          <= 1'b1;
                        end
`endif
                    end
                end
                BUSY: begin
                    if (dmem_resp) begin
                        dmem_read  <= 1'b0;
                        dmem_write <= 1'b0;
                        if (!write_q) begin
                            rsp_rdata <= load_c;
                        end
                        rsp_valid  <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef MEM_ACCESS_MISALIGN_TRAP_EN
    assign rsp_err = 1'b0;
`endif

endmodule
